// File: rtl/mem_access_seq_pkg.sv
// Shared definitions for the load/store sequencer: op encodings, FSM states,
// access sizes and the fixed memory word width.
package mem_access_seq_pkg;

    localparam int MEM_W = 16;

    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b011;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;
    localparam int         STORE_BIT = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD0,
        ST_RD1,
        ST_WR0,
        ST_WR1,
        ST_RESP
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } size_t;

    // Undefined opcodes fall into the word bucket.
    function automatic size_t op_size(input logic [2:0] op);
        case (op)
            OP_B, OP_BU: op_size = SZ_BYTE;
            OP_H, OP_HU: op_size = SZ_HALF;
            OP_W:        op_size = SZ_WORD;
            default:     op_size = SZ_WORD;
        endcase
    endfunction

    function automatic logic is_misaligned(input size_t sz, input logic [1:0] lsb);
        case (sz)
            SZ_HALF: is_misaligned = lsb[0];
            SZ_WORD: is_misaligned = (lsb != 2'b00);
            default: is_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_seq_if.sv
// Core request/response handshake plus the 16-bit data memory bus.
// slave = sequencer side; master = core and memory side.
interface mem_access_seq_if #(
    parameter int ADDR_W = 32
) ();
    import mem_access_seq_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [MEM_W-1:0]  mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [MEM_W-1:0]  mem_rdata;

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_addr, mem_wdata, mem_we, mem_re
    );

    modport master (
        output req_valid, req_op, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_addr, mem_wdata, mem_we, mem_re
    );

endinterface

// File: rtl/mem_access_seq_load_align_ext.sv
// Big-endian byte/half select from a memory halfword with sign or zero
// extension to 32 bits; shared with the writeback stage.
module mem_access_seq_load_align_ext
    import mem_access_seq_pkg::*;
(
    input  logic [2:0]       op,
    input  logic             byte_sel,
    input  logic [MEM_W-1:0] half_in,
    output logic [31:0]      data_out
);

    logic [7:0] byte_val;
    logic       signed_ld;

    assign byte_val  = byte_sel ? half_in[7:0] : half_in[15:8];
    assign signed_ld = ~op[2];

    always_comb begin
        case (op_size(op))
            SZ_BYTE: data_out = {{24{signed_ld & byte_val[7]}}, byte_val};
            SZ_HALF: data_out = {{16{signed_ld & half_in[15]}}, half_in};
            default: data_out = {16'h0000, half_in};
        endcase
    end

endmodule

// File: rtl/mem_access_seq.sv
// Load/store sequencer: splits one 32-bit MIPS load/store into one or two
// 16-bit memory beats, with byte-store read-modify-write and load extension.
module mem_access_seq #(
    parameter int ADDR_W          = 32,
    parameter int MEM_W           = 16,
    parameter bit ERR_ON_MISALIGN = 1'b1
) (
    input logic            clk,
    input logic            rst_n,
    mem_access_seq_if.slave bus
);
    import mem_access_seq_pkg::*;

    if (MEM_W != 16) begin : g_mem_w_check
        $error("mem_access_seq: MEM_W must be 16");
    end

    state_t            state_q, state_d;
    logic [3:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [MEM_W-1:0]  hold_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    size_t             req_sz, sz_q;
    logic              req_misaligned;
    logic [ADDR_W-1:0] addr_cap;
    logic              accept, hold_load, resp_load;
    logic [31:0]       rdata_d;
    logic              err_d;
    logic [31:0]       ext_data;
    logic [ADDR_W-1:0] half_base;
    logic [MEM_W-1:0]  merged;

    assign req_sz         = op_size(bus.req_op[2:0]);
    assign sz_q           = op_size(op_q[2:0]);
    assign req_misaligned = is_misaligned(req_sz, bus.req_addr[1:0]);

    // Without error reporting, misaligned halves/words are silently aligned.
    always_comb begin
        addr_cap = bus.req_addr;
        if (!ERR_ON_MISALIGN) begin
            if (req_sz == SZ_WORD)      addr_cap[1:0] = 2'b00;
            else if (req_sz == SZ_HALF) addr_cap[0]   = 1'b0;
        end
    end

    mem_access_seq_load_align_ext u_align_ext (
        .op       (op_q[2:0]),
        .byte_sel (addr_q[0]),
        .half_in  (bus.mem_rdata),
        .data_out (ext_data)
    );

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        hold_load = 1'b0;
        resp_load = 1'b0;
        rdata_d   = '0;
        err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    accept = 1'b1;
                    if (ERR_ON_MISALIGN && req_misaligned) begin
                        state_d   = ST_RESP;
                        resp_load = 1'b1;
                        err_d     = 1'b1;
                    end else if (bus.req_op[STORE_BIT] && req_sz != SZ_BYTE) begin
                        state_d = ST_WR0;
                    end else begin
                        state_d = ST_RD0;
                    end
                end
            end
            ST_RD0: begin
                hold_load = 1'b1;
                if (op_q[STORE_BIT]) begin
                    state_d = ST_WR0;
                end else if (sz_q == SZ_WORD) begin
                    state_d = ST_RD1;
                end else begin
                    state_d   = ST_RESP;
                    resp_load = 1'b1;
                    rdata_d   = ext_data;
                end
            end
            ST_RD1: begin
                state_d   = ST_RESP;
                resp_load = 1'b1;
                rdata_d   = {hold_q, bus.mem_rdata};
            end
            ST_WR0: begin
                if (sz_q == SZ_WORD) begin
                    state_d = ST_WR1;
                end else begin
                    state_d   = ST_RESP;
                    resp_load = 1'b1;
                end
            end
            ST_WR1: begin
                state_d   = ST_RESP;
                resp_load = 1'b1;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every captured register is cleared on reset so an aborted access
    // leaves nothing stale behind for the next request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            hold_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                op_q    <= bus.req_op;
                addr_q  <= addr_cap;
                wdata_q <= bus.req_wdata;
            end
            if (hold_load) hold_q <= bus.mem_rdata;
            if (resp_load) begin
                rdata_q <= rdata_d;
                err_q   <= err_d;
            end
        end
    end

    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.resp_valid = (state_q == ST_RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    assign bus.mem_re     = (state_q == ST_RD0) || (state_q == ST_RD1);
    assign bus.mem_we     = (state_q == ST_WR0) || (state_q == ST_WR1);

    assign half_base = {addr_q[ADDR_W-1:1], 1'b0};
    // Big-endian: even byte address is the upper byte of the halfword.
    assign merged = addr_q[0] ? {hold_q[15:8], wdata_q[7:0]}
                              : {wdata_q[7:0], hold_q[7:0]};

    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        case (state_q)
            ST_RD0: bus.mem_addr = half_base;
            ST_RD1: bus.mem_addr = half_base + ADDR_W'(2);
            ST_WR0: begin
                bus.mem_addr = half_base;
                case (sz_q)
                    SZ_WORD: bus.mem_wdata = wdata_q[31:16];
                    SZ_HALF: bus.mem_wdata = wdata_q[15:0];
                    default: bus.mem_wdata = merged;
                endcase
            end
            ST_WR1: begin
                bus.mem_addr  = half_base + ADDR_W'(2);
                bus.mem_wdata = wdata_q[15:0];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_access_seq.sv
// Self-checking bench for mem_access_seq: directed table, beat-level corner
// cases, back-to-back throughput, mid-access reset and randomized traffic.
module tb_mem_access_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_access_seq_if #(.ADDR_W(32)) bus ();

    mem_access_seq #(
        .ADDR_W          (32),
        .MEM_W           (16),
        .ERR_ON_MISALIGN (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Word-organised memory seen by the DUT; byte-organised reference image.
    logic [15:0] tb_mem  [0:255];
    logic [7:0]  ref_mem [0:511];

    assign bus.mem_rdata = tb_mem[bus.mem_addr[8:1]];
    always @(posedge clk) if (bus.mem_we) tb_mem[bus.mem_addr[8:1]] <= bus.mem_wdata;

    int checks = 0;
    int failures = 0;
    int viol = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.mem_re && bus.mem_we) viol++;
            if (!bus.mem_we && bus.mem_wdata != 16'h0) viol++;
            if ((bus.mem_re || bus.mem_we) && bus.mem_addr[0]) viol++;
        end
    end

    logic [31:0] beat_addr [4];
    logic [15:0] beat_data [4];
    logic        beat_we   [4];
    int          nbeats;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic run_req(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output logic err, output int lat);
        int guard = 0;
        nbeats = 0;
        lat = 0;
        rdata = '0;
        err = 1'b0;
        @(negedge clk);
        while (!bus.req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.req_ready) begin
            check("ready_timeout", 32'(bus.req_ready), 32'd1);
            return;
        end
        bus.req_op = op;
        bus.req_addr = addr;
        bus.req_wdata = wdata;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (bus.mem_re || bus.mem_we) begin
                if (nbeats < 4) begin
                    beat_addr[nbeats] = bus.mem_addr;
                    beat_data[nbeats] = bus.mem_wdata;
                    beat_we[nbeats] = bus.mem_we;
                end
                nbeats++;
            end
        end while (!bus.resp_valid && lat < 12);
        rdata = bus.resp_rdata;
        err = bus.resp_err;
    endtask

    function automatic int size_of(input logic [2:0] op);
        if (op == 3'd0 || op == 3'd4) return 1;
        if (op == 3'd1 || op == 3'd5) return 2;
        return 4;
    endfunction

    // Reference: byte-addressed big-endian memory, results from the access rules.
    task automatic model(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rd, output logic err, output int n);
        int s;
        int a;
        logic [31:0] v;
        s = size_of(op[2:0]);
        a = int'(addr[8:0]);
        rd = '0;
        err = 1'b0;
        v = '0;
        if ((s == 2 && addr[0]) || (s == 4 && addr[1:0] != 2'b00)) begin
            err = 1'b1;
            n = 1;
            return;
        end
        if (op[3]) begin
            for (int i = 0; i < s; i++) ref_mem[a + i] = wdata[8 * (s - 1 - i) +: 8];
            n = (s == 2) ? 2 : 3;
        end else begin
            for (int i = 0; i < s; i++) v = (v << 8) | 32'(ref_mem[a + i]);
            if (!op[2] && s < 4 && v[8 * s - 1]) v = v | ~((32'd1 << (8 * s)) - 32'd1);
            rd = v;
            n = (s == 4) ? 3 : 2;
        end
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_n;
    } vec_t;

    vec_t vecs [16];

    initial begin
        logic [31:0] rd, m_rd;
        logic        er, m_er;
        int          lat, m_n;
        logic [3:0]  b2b_op [6];
        logic [31:0] b2b_addr [6];
        logic [31:0] b2b_wd [6];
        logic [31:0] b2b_exp [6];
        int          acc_cyc [6];
        logic [31:0] resp_q [$];
        int          idx, cyc, mism;
        logic        rdy, seen;
        logic [3:0]  rops [14];

        for (int i = 0; i < 256; i++) tb_mem[i] = 16'h0;
        for (int i = 0; i < 512; i++) ref_mem[i] = 8'h0;
        bus.req_valid = 1'b0;
        bus.req_op = '0;
        bus.req_addr = '0;
        bus.req_wdata = '0;

        vecs[0]  = '{4'hB, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 3};
        vecs[1]  = '{4'h3, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 3};
        vecs[2]  = '{4'h1, 32'h12, 32'h0,        32'hFFFFBEEF, 1'b0, 2};
        vecs[3]  = '{4'h5, 32'h12, 32'h0,        32'h0000BEEF, 1'b0, 2};
        vecs[4]  = '{4'h0, 32'h11, 32'h0,        32'hFFFFFFAD, 1'b0, 2};
        vecs[5]  = '{4'h4, 32'h13, 32'h0,        32'h000000EF, 1'b0, 2};
        vecs[6]  = '{4'h8, 32'h11, 32'h55,       32'h0,        1'b0, 3};
        vecs[7]  = '{4'h3, 32'h10, 32'h0,        32'hDE55BEEF, 1'b0, 3};
        vecs[8]  = '{4'h3, 32'h12, 32'h0,        32'h0,        1'b1, 1};
        vecs[9]  = '{4'h9, 32'h11, 32'h1234,     32'h0,        1'b1, 1};
        vecs[10] = '{4'h1, 32'h10, 32'h0,        32'hFFFFDE55, 1'b0, 2};
        vecs[11] = '{4'h2, 32'h10, 32'h0,        32'hDE55BEEF, 1'b0, 3};
        vecs[12] = '{4'h4, 32'h10, 32'h0,        32'h000000DE, 1'b0, 2};
        vecs[13] = '{4'h9, 32'h14, 32'hFFFF8001, 32'h0,        1'b0, 2};
        vecs[14] = '{4'h0, 32'h15, 32'h0,        32'h00000001, 1'b0, 2};
        vecs[15] = '{4'h0, 32'h14, 32'h0,        32'hFFFFFF80, 1'b0, 2};

        // Reset state
        #12;
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'd0);
        check("rst_resp_err", 32'(bus.resp_err), 32'd0);
        check("rst_mem_we_re", {30'd0, bus.mem_we, bus.mem_re}, 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 16; i++) begin
            run_req(vecs[i].op, vecs[i].addr, vecs[i].wdata, rd, er, lat);
            model(vecs[i].op, vecs[i].addr, vecs[i].wdata, m_rd, m_er, m_n);
            check($sformatf("row%0d_rdata", i), rd, vecs[i].exp_rd);
            check($sformatf("row%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
            check($sformatf("row%0d_latency", i), 32'(lat), 32'(vecs[i].exp_n));
            if (vecs[i].exp_err) check($sformatf("row%0d_no_beats", i), 32'(nbeats), 32'd0);
        end

        // Beat-level sequences
        run_req(4'hB, 32'h40, 32'h01234567, rd, er, lat);
        model(4'hB, 32'h40, 32'h01234567, m_rd, m_er, m_n);
        check("sw_nbeats", 32'(nbeats), 32'd2);
        check("sw_b0", {beat_addr[0][15:0], beat_data[0]}, 32'h0040_0123);
        check("sw_b1", {beat_addr[1][15:0], beat_data[1]}, 32'h0042_4567);
        check("sw_we", {30'd0, beat_we[0], beat_we[1]}, 32'd3);
        run_req(4'h3, 32'h40, 32'h0, rd, er, lat);
        model(4'h3, 32'h40, 32'h0, m_rd, m_er, m_n);
        check("lw_beats", {beat_addr[0][15:0], beat_addr[1][15:0]}, 32'h0040_0042);
        check("lw_re", {30'd0, beat_we[0], beat_we[1]}, 32'd0);
        check("lw_rdata", rd, 32'h01234567);
        @(negedge clk);
        @(negedge clk);
        check("resp_pulse_one_cycle", 32'(bus.resp_valid), 32'd0);
        check("resp_rdata_hold", bus.resp_rdata, 32'h01234567);
        run_req(4'h8, 32'h41, 32'h000000AB, rd, er, lat);
        model(4'h8, 32'h41, 32'h000000AB, m_rd, m_er, m_n);
        check("sb_nbeats", 32'(nbeats), 32'd2);
        check("sb_rd_beat", {beat_addr[0][15:0], 15'd0, beat_we[0]}, 32'h0040_0000);
        check("sb_wr_beat", {beat_addr[1][15:0], beat_data[1]}, 32'h0040_01AB);
        check("sb_rdata_zero", rd, 32'h0);

        // Back-to-back with req_valid held high
        for (int i = 0; i < 6; i++) begin
            b2b_op[i] = (i % 2 == 0) ? 4'hB : 4'h3;
            b2b_addr[i] = 32'h60 + 32'(4 * (i / 2));
            b2b_wd[i] = $urandom;
        end
        idx = 0;
        cyc = 0;
        @(negedge clk);
        bus.req_op = b2b_op[0];
        bus.req_addr = b2b_addr[0];
        bus.req_wdata = b2b_wd[0];
        bus.req_valid = 1'b1;
        while (idx < 6 && cyc < 200) begin
            rdy = bus.req_ready;
            if (bus.resp_valid) resp_q.push_back(bus.resp_rdata);
            @(posedge clk);
            cyc++;
            if (rdy) begin
                acc_cyc[idx] = cyc;
                model(b2b_op[idx], b2b_addr[idx], b2b_wd[idx], b2b_exp[idx], m_er, m_n);
                idx++;
                #1;
                if (idx < 6) begin
                    bus.req_op = b2b_op[idx];
                    bus.req_addr = b2b_addr[idx];
                    bus.req_wdata = b2b_wd[idx];
                end else begin
                    bus.req_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (bus.resp_valid) resp_q.push_back(bus.resp_rdata);
            @(negedge clk);
        end
        check("b2b_accepted", 32'(idx), 32'd6);
        for (int i = 1; i < idx; i++)
            check($sformatf("b2b_spacing%0d", i), 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd4);
        check("b2b_resp_count", 32'(resp_q.size()), 32'd6);
        if (resp_q.size() == 6 && idx == 6)
            for (int i = 0; i < 6; i++) check($sformatf("b2b_rdata%0d", i), resp_q[i], b2b_exp[i]);

        // Reset during WR1 of a word store
        run_req(4'hB, 32'h20, 32'h11112222, rd, er, lat);
        model(4'hB, 32'h20, 32'h11112222, m_rd, m_er, m_n);
        @(negedge clk);
        bus.req_op = 4'hB;
        bus.req_addr = 32'h20;
        bus.req_wdata = 32'hAAAABBBB;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(posedge clk);
        #2;
        check("wr1_we_before_rst", {15'd0, bus.mem_we, bus.mem_addr[15:0]}, 32'h0001_0022);
        rst_n = 1'b0;
        #1;
        check("rst_async_we", 32'(bus.mem_we), 32'd0);
        check("rst_async_ready", 32'(bus.req_ready), 32'd1);
        check("rst_async_rdata", bus.resp_rdata, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ref_mem[32'h20] = 8'hAA;
        ref_mem[32'h21] = 8'hAA;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.resp_valid) seen = 1'b1;
        end
        check("rst_no_resp", 32'(seen), 32'd0);
        check("rst_ready_after", 32'(bus.req_ready), 32'd1);
        check("rst_mem_hi", 32'(tb_mem[8'h10]), 32'h0000AAAA);
        check("rst_mem_lo", 32'(tb_mem[8'h11]), 32'h00002222);

        // Randomized traffic against the reference model
        rops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
                 4'h8, 4'h9, 4'hA, 4'hB, 4'hE, 4'hF};
        for (int t = 0; t < 300; t++) begin
            logic [3:0]  op;
            logic [31:0] addr, wd;
            op = rops[$urandom_range(0, 13)];
            addr = 32'($urandom_range(0, 32'h1F0));
            wd = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (size_of(op[2:0]) == 4) addr[1:0] = 2'b00;
                else if (size_of(op[2:0]) == 2) addr[0] = 1'b0;
            end
            run_req(op, addr, wd, rd, er, lat);
            model(op, addr, wd, m_rd, m_er, m_n);
            check($sformatf("rnd%0d_rdata op=%h a=%h", t, op, addr), rd, m_rd);
            check($sformatf("rnd%0d_err", t), 32'(er), 32'(m_er));
            check($sformatf("rnd%0d_latency", t), 32'(lat), 32'(m_n));
        end

        mism = 0;
        for (int i = 0; i < 256; i++)
            if (tb_mem[i] !== {ref_mem[2*i], ref_mem[2*i+1]}) mism++;
        check("mem_image", 32'(mism), 32'd0);
        check("bus_rules", 32'(viol), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_seq.md
Name: mem_access_seq

Overview:
Load/store sequencer between the single-cycle datapath's MEM stage and the 16-bit-wide data memory. It takes one 32-bit MIPS load or store request and splits it into one or two 16-bit memory beats:
- lb, lbu, lh, lhu, lw
- sb, sh, sw
It performs sign/zero extension on loads and read-modify-write for byte stores. It stalls the core through a ready/valid handshake until the access completes. Byte order is big-endian.

Parameters:
ADDR_W, 32, request/memory byte-address width
MEM_W, 16, memory word width; fixed at 16, any other value is a configuration error
ERR_ON_MISALIGN, 1, 1 = misaligned access returns error with no memory traffic; 0 = low address bits are forced to alignment and the access proceeds

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  core presents a request
req_ready  out  1  high only in IDLE; request accepted when req_valid && req_ready at a rising edge
req_op  in  4  [3]=store, [2:0]=MIPS opcode[2:0]: 000 byte, 001 half, 011 word, 100 byte unsigned, 101 half unsigned
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-justified for sb/sh
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  load result, valid with resp_valid; 0 for stores and errors
resp_err  out  1  misalignment flag, valid with resp_valid
mem_addr  out  ADDR_W  halfword byte address to memory, bit0 always 0
mem_wdata  out  MEM_W  write data to memory
mem_we  out  1  memory write enable; memory writes at the rising edge ending the cycle
mem_re  out  1  memory read enable
mem_rdata  in  MEM_W  combinational read data from memory, sampled in the same cycle as mem_re

Behaviour:
- Reset (asynchronous, immediate on rst_n low):
  - state IDLE; req_ready=1.
  - resp_valid=0, resp_rdata=0, resp_err=0.
  - mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0.
  - All captured request registers cleared.
- Request capture: on acceptance, latch op, addr and wdata. Inputs are ignored until the next IDLE.
- States: IDLE, RD0, RD1, WR0, WR1, RESP.
- Outputs are Moore-decoded from state plus latched registers only. mem_* never depends combinationally on req_*.
- Let A = latched address. hiA = {A[ADDR_W-1:1],0} for half/byte accesses; for word accesses beat 0 uses A and beat 1 uses A+2.
- Transitions from the acceptance edge (N = cycles from acceptance to resp_valid):
  - lw: RD0 (A, capture bits [31:16]) -> RD1 (A+2, capture bits [15:0]) -> RESP. N=3.
  - lh/lhu/lb/lbu: RD0 -> RESP. N=2.
  - sw: WR0 (A, wdata[31:16]) -> WR1 (A+2, wdata[15:0]) -> RESP. N=3.
  - sh: WR0 (wdata[15:0]) -> RESP. N=2.
  - sb: RD0 (read halfword into merge register) -> WR0 (merged halfword) -> RESP. N=3.
    - A[0]=0 replaces bits [15:8] with wdata[7:0].
    - A[0]=1 replaces bits [7:0] with wdata[7:0].
  - Misaligned with ERR_ON_MISALIGN=1 -> RESP directly, resp_err=1, no mem_re/mem_we ever asserted. N=1.
    - half: A[0]=1.
    - word: A[1:0]!=0.
    - Byte accesses are never misaligned.
- RESP lasts one cycle, then IDLE. req_ready returns high the cycle after RESP. Back-to-back throughput is therefore N+1 cycles per request. There is no response backpressure.
- Load extension:
  - Byte select: A[0]=0 -> mem_rdata[15:8], A[0]=1 -> mem_rdata[7:0].
  - op[2]=0 sign-extends to 32 bits; op[2]=1 zero-extends.
- Undefined op codes (010, 110, 111) are treated as word accesses.
- mem_re and mem_we are never high in the same cycle. mem_wdata=0 whenever mem_we=0.
- Reset mid-operation aborts immediately and no resp_valid is produced. A sw aborted after WR0 leaves the high half written; this is accepted behaviour and the core re-issues.
- resp_rdata holds its value after RESP until the next RESP or reset.

Decomposition:
- Shared package (mem_pkg):
  - op encodings: OP_B, OP_H, OP_W, OP_BU, OP_HU and the STORE bit.
  - FSM state encoding.
  - MEM_W constant.
- One sub-module, load_align_ext: combinational byte/half select plus sign/zero extension, reused by the writeback stage later.

Test Plan:
- Reset, then sw addr=0x10 wdata=0xDEADBEEF -> WR0 addr 0x10 data 0xDEAD, WR1 addr 0x12 data 0xBEEF, resp_valid 3 cycles after acceptance, err=0.
- Then lw addr=0x10 -> RD0/RD1 at 0x10/0x12, resp_rdata=0xDEADBEEF at cycle 3; lh 0x12 -> 0xFFFFBEEF; lhu 0x12 -> 0x0000BEEF.
- lb 0x11 -> 0xFFFFFFAD; lbu 0x13 -> 0x000000EF; sb 0x11 wdata=0x55 -> RD0 then WR0 at 0x10 with data 0xDE55; subsequent lw 0x10 -> 0xDE55BEEF.
- lw 0x12 and sh 0x11 with ERR_ON_MISALIGN=1 -> resp_valid one cycle after acceptance, resp_err=1, resp_rdata=0, mem_we/mem_re never asserted.
- Hold req_valid high with alternating sw/lw -> each accepted only when req_ready=1, spacing of 4 cycles, no request dropped or duplicated.
- Assert rst_n low during WR1 of sw 0x20 -> mem_we drops without a clock edge, no resp_valid, req_ready=1 after release; memory at 0x20 holds the new high half and 0x22 holds the old value.
